lc3b_dmem_responder: RTL and testbench
======================================

// Module: lc3b_dmem_responder
// PURPOSE
//  Data-memory responder for the LC-3b pipeline MEM stage. Answers d_mem_read/d_mem_write strobes
//  from the control word with a fixed-latency, single-outstanding, byte-maskable word access.
//  Backs an on-chip word array. Serves as the data-side memory in the pipelined CPU and its benches.
//  Registered mem_resp handshake; the MEM stage stalls (load_pipe_mem=0) until resp.
// PARAMETERS
//  DEPTH_WORDS  256  words of storage; word index = d_mem_address[15:1]
//  LATENCY      2    cycles from acceptance to d_mem_resp; legal range 1..15
// PORTS
//  clk                input   1   single clock; all state changes on rising edge
//  rst_n              input   1   synchronous, active-low reset
//  d_mem_read         input   1   read request; held until d_mem_resp
//  d_mem_write        input   1   write request; held until d_mem_resp
//  d_mem_address      input   16  byte address (lc3b_word)
//  d_mem_byte_enable  input   2   write byte mask; [1]=high byte, [0]=low byte
//  d_mem_wdata        input   16  write data
//  d_mem_rdata        output  16  read data; valid only in the d_mem_resp cycle
//  d_mem_resp         output  1   one-cycle completion pulse
//  d_mem_err          output  1   one-cycle pulse with d_mem_resp on a rejected request
// BEHAVIOUR
//  Interface: one clock; reset is synchronous and active-low (rst_n sampled on clk rising edge).
//  Reset: state=IDLE, counter=0, d_mem_resp=0, d_mem_err=0, d_mem_rdata=16'h0000.
//    Array contents are NOT reset. Reset mid-access aborts it: no resp, no write commit.
//  States: IDLE, BUSY, RESP.
//  IDLE:
//    - (read|write)=1 at edge t: latch address, mask, wdata, op; counter=LATENCY-1;
//      go to BUSY, or straight to RESP if LATENCY==1.
//    - read&write both 1: reject. No array access; RESP with d_mem_err=1.
//  BUSY: counter decrements each cycle; at 0 go to RESP. Input changes are ignored (latched copy used).
//  Commit timing:
//    - Writes commit to the array on the edge entering RESP.
//    - Reads sample the array on that same edge into d_mem_rdata.
//  RESP: d_mem_resp=1 (and d_mem_err if rejected) for exactly one cycle; next state IDLE.
//    Requests seen while in RESP are not accepted.
//  Throughput: one access per LATENCY+1 cycles; the accepting edge is t, resp is visible t+LATENCY.
//  Read: full word returned; d_mem_address[0] ignored. LDB byte select is done downstream.
//  Write: bytes written only where d_mem_byte_enable=1; mask 2'b00 completes with no change.
//  Out of range (word index >= DEPTH_WORDS):
//    - read returns 16'h0000 with d_mem_err=1
//    - write is dropped with d_mem_err=1
//    - resp timing is unchanged.
//  d_mem_rdata holds its last value outside RESP; it is updated only on reads.
//  Read-after-write to the same address in consecutive accesses returns the new data (no bypass needed).
// STRUCTURE
//  lc3b_types additions:
//    - lc3b_mem_wmask (logic [1:0])
//    - lc3b_dmem_state enum {DMEM_IDLE, DMEM_BUSY, DMEM_RESP}
//  Sub-module lc3b_dmem_array: DEPTH_WORDS x 16 storage with a per-byte write mask.
//    One synchronous write port plus a synchronous read port, used on the commit edge.
//  The counter width is $clog2(LATENCY+1). Parameter legality is checked with an elaboration-time assertion.
// TESTING
//  1 Reset: rst_n=0 for 2 cycles with d_mem_read=1 -> resp=0, err=0, rdata=0.
//    Release rst_n -> first resp LATENCY cycles after acceptance.
//  2 Write then read: write 16'hBEEF to 16'h0040 mask 2'b11, then read 16'h0040
//    -> both resp at t+2 (LATENCY=2); rdata=16'hBEEF.
//  3 Byte write: mask 2'b01 wdata 16'h1234 over 16'hBEEF, then read -> 16'hBE34;
//    mask 2'b10 wdata 16'hAA00 -> 16'hAA34.
//  4 Illegal requests:
//    - read&write both 1 -> resp with err=1, array unchanged.
//    - read of word index 256 (addr 16'h0200) -> rdata=0, err=1.
//  5 Reset mid-access: write accepted, rst_n low during BUSY -> no resp, location unchanged on re-read.
//  6 Back-to-back and latency sweep:
//    - hold read high across resp -> the second access is accepted only after RESP->IDLE;
//      resp pulses are exactly LATENCY+1 cycles apart.
//    - sweep LATENCY in {1,2,5}.

Source files
------------

// File: rtl/lc3b_dmem_responder_pkg.sv
// Shared types for the LC-3b data-memory responder: word/mask types and FSM state encoding.
package lc3b_dmem_responder_pkg;

   typedef logic [15:0] lc3b_word;
   typedef logic [1:0]  lc3b_mem_wmask;
   typedef logic [14:0] lc3b_word_idx;

   typedef enum logic [1:0] {
      DMEM_IDLE,
      DMEM_BUSY,
      DMEM_RESP
   } lc3b_dmem_state;

   // Byte address to word index; bit 0 only matters to downstream byte select.
   function automatic lc3b_word_idx word_idx(input lc3b_word addr);
      return addr[15:1];
   endfunction

endpackage

// File: rtl/lc3b_dmem_array.sv
// Word storage with per-byte write mask and a registered read port, both used on the commit edge.
module lc3b_dmem_array
   import lc3b_dmem_responder_pkg::*;
#(
   parameter int DEPTH_WORDS = 256
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          wr_en,
   input  logic          rd_en,
   input  lc3b_word_idx  idx,
   input  lc3b_mem_wmask wr_mask,
   input  lc3b_word      wr_data,
   output lc3b_word      rd_data
);

   localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

   lc3b_word       mem [DEPTH_WORDS];
   logic           in_range;
   logic [AW-1:0]  addr;

   assign in_range = (int'(idx) < DEPTH_WORDS);
   assign addr     = idx[AW-1:0];

   // Contents are deliberately left unreset.
   always_ff @(posedge clk) begin
      if (wr_en && in_range) begin
         if (wr_mask[0]) mem[addr][7:0]  <= wr_data[7:0];
         if (wr_mask[1]) mem[addr][15:8] <= wr_data[15:8];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_data <= '0;
      end else if (rd_en) begin
         rd_data <= in_range ? mem[addr] : '0;
      end
   end

endmodule

// File: rtl/lc3b_dmem_responder.sv
// Fixed-latency, single-outstanding data-memory responder for the LC-3b MEM stage.
module lc3b_dmem_responder
   import lc3b_dmem_responder_pkg::*;
#(
   parameter int DEPTH_WORDS = 256,
   parameter int LATENCY     = 2
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          d_mem_read,
   input  logic          d_mem_write,
   input  lc3b_word      d_mem_address,
   input  lc3b_mem_wmask d_mem_byte_enable,
   input  lc3b_word      d_mem_wdata,
   output lc3b_word      d_mem_rdata,
   output logic          d_mem_resp,
   output logic          d_mem_err
);

   localparam int CW = $clog2(LATENCY + 1);

   if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
      $error("lc3b_dmem_responder: LATENCY must be in 1..15");
   end
   if (DEPTH_WORDS < 1) begin : g_bad_depth
      $error("lc3b_dmem_responder: DEPTH_WORDS must be at least 1");
   end

   lc3b_dmem_state state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic           op_rd_q, op_wr_q;
   lc3b_word_idx   idx_q;
   lc3b_mem_wmask  mask_q;
   lc3b_word       wdata_q;
   logic           err_q;

   logic           commit;
   logic           use_in;
   logic           c_rd, c_wr, c_reject, c_oor;
   lc3b_word_idx   c_idx;
   lc3b_mem_wmask  c_mask;
   lc3b_word       c_wdata;
   logic           addr_lsb_unused;

   assign addr_lsb_unused = d_mem_address[0];

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      commit  = 1'b0;
      case (state_q)
         DMEM_IDLE: begin
            if (d_mem_read || d_mem_write) begin
               cnt_d   = CW'(LATENCY - 1);
               state_d = (LATENCY == 1) ? DMEM_RESP : DMEM_BUSY;
               commit  = (LATENCY == 1);
            end
         end
         DMEM_BUSY: begin
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               state_d = DMEM_RESP;
               commit  = 1'b1;
            end
         end
         DMEM_RESP: state_d = DMEM_IDLE;
         default:   state_d = DMEM_IDLE;
      endcase
   end

   // With LATENCY==1 the commit edge is the accepting edge, so the live inputs are used.
   assign use_in   = (state_q == DMEM_IDLE);
   assign c_rd     = use_in ? d_mem_read              : op_rd_q;
   assign c_wr     = use_in ? d_mem_write             : op_wr_q;
   assign c_idx    = use_in ? word_idx(d_mem_address) : idx_q;
   assign c_mask   = use_in ? d_mem_byte_enable       : mask_q;
   assign c_wdata  = use_in ? d_mem_wdata             : wdata_q;
   assign c_reject = c_rd && c_wr;
   assign c_oor    = (int'(c_idx) >= DEPTH_WORDS);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= DMEM_IDLE;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         err_q   <= commit && (c_reject || c_oor);
      end
   end

   // Rejected requests still run the full latency so the MEM stage sees uniform timing.
   always_ff @(posedge clk) begin
      if (state_q == DMEM_IDLE && (d_mem_read || d_mem_write)) begin
         op_rd_q <= d_mem_read;
         op_wr_q <= d_mem_write;
         idx_q   <= word_idx(d_mem_address);
         mask_q  <= d_mem_byte_enable;
         wdata_q <= d_mem_wdata;
      end
   end

   lc3b_dmem_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (rst_n && commit && c_wr && !c_reject),
      .rd_en   (rst_n && commit && c_rd && !c_reject),
      .idx     (c_idx),
      .wr_mask (c_mask),
      .wr_data (c_wdata),
      .rd_data (d_mem_rdata)
   );

   assign d_mem_resp = (state_q == DMEM_RESP);
   assign d_mem_err  = err_q;

endmodule

// File: tb/tb_lc3b_dmem_responder.sv
// Bench for lc3b_dmem_responder: three instances (LATENCY 1, 2, 5) against a word-array reference model.
module tb_lc3b_dmem_responder;

   localparam int NI = 3;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        rd    [NI];
   logic        wr    [NI];
   logic [15:0] addr  [NI];
   logic [1:0]  be    [NI];
   logic [15:0] wdata [NI];
   logic [15:0] rdata [NI];
   logic        resp  [NI];
   logic        err   [NI];

   always #5 clk = ~clk;

   for (genvar g = 0; g < NI; g++) begin : g_dut
      lc3b_dmem_responder #(
         .DEPTH_WORDS (256),
         .LATENCY     ((g == 0) ? 1 : ((g == 1) ? 2 : 5))
      ) dut (
         .clk               (clk),
         .rst_n             (rst_n),
         .d_mem_read        (rd[g]),
         .d_mem_write       (wr[g]),
         .d_mem_address     (addr[g]),
         .d_mem_byte_enable (be[g]),
         .d_mem_wdata       (wdata[g]),
         .d_mem_rdata       (rdata[g]),
         .d_mem_resp        (resp[g]),
         .d_mem_err         (err[g])
      );
   end

   // ---------------- reference model ----------------
   logic [15:0] mem_m   [NI][256];
   bit          known_m [NI][256];
   logic [15:0] last_rd [NI];
   bit          last_known [NI];

   int errors = 0;
   int checks = 0;

   function automatic int lat_of(input int s);
      return (s == 0) ? 1 : ((s == 1) ? 2 : 5);
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic model_access(input int s, input bit r, input bit w, input logic [15:0] a,
                               input logic [1:0] m, input logic [15:0] d,
                               output bit e_err, output bit e_known, output logic [15:0] e_rd);
      int idx;
      bit rej, oor;
      idx   = int'(a[15:1]);
      rej   = r && w;
      oor   = idx >= 256;
      e_err = rej || oor;
      if (!rej && w && !oor) begin
         if (m[0]) mem_m[s][idx][7:0]  = d[7:0];
         if (m[1]) mem_m[s][idx][15:8] = d[15:8];
         if (m == 2'b11) known_m[s][idx] = 1'b1;
      end
      if (!rej && r) begin
         if (oor) begin
            last_rd[s]    = 16'h0000;
            last_known[s] = 1'b1;
         end else begin
            last_rd[s]    = mem_m[s][idx];
            last_known[s] = known_m[s][idx];
         end
      end
      e_known = last_known[s];
      e_rd    = last_rd[s];
   endtask

   // ---------------- driver ----------------
   task automatic run_access(input int s, input bit r, input bit w, input logic [15:0] a,
                             input logic [1:0] m, input logic [15:0] d, input string tag);
      int k;
      bit got;
      bit e_err, e_known;
      logic [15:0] e_rd;
      @(negedge clk);
      rd[s] = r; wr[s] = w; addr[s] = a; be[s] = m; wdata[s] = d;
      k = 0;
      got = 1'b0;
      while (!got && k < 40) begin
         @(posedge clk);
         k++;
         @(negedge clk);
         if (resp[s]) got = 1'b1;
      end
      model_access(s, r, w, a, m, d, e_err, e_known, e_rd);
      check({tag, "_lat"}, k, lat_of(s));
      check({tag, "_err"}, err[s], e_err);
      if (e_known) check({tag, "_rdata"}, rdata[s], e_rd);
      rd[s] = 1'b0;
      wr[s] = 1'b0;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      int first [NI];
      int k1, k2;
      bit all_seen;
      bit e_err, e_known;
      logic [15:0] e_rd;

      for (int s = 0; s < NI; s++) begin
         rd[s] = 1'b0; wr[s] = 1'b0; addr[s] = 16'h0; be[s] = 2'b00; wdata[s] = 16'h0;
      end

      // Reset with read held high
      rst_n = 1'b0;
      for (int s = 0; s < NI; s++) begin
         rd[s] = 1'b1; addr[s] = 16'h0040; be[s] = 2'b11;
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      for (int s = 0; s < NI; s++) begin
         check($sformatf("rst_resp%0d", s), resp[s], 1'b0);
         check($sformatf("rst_err%0d", s), err[s], 1'b0);
         check($sformatf("rst_rdata%0d", s), rdata[s], 16'h0000);
         last_rd[s] = 16'h0000;
         last_known[s] = 1'b1;
         first[s] = 0;
      end
      rst_n = 1'b1;
      k = 0;
      all_seen = 1'b0;
      while (!all_seen && k < 30) begin
         @(posedge clk);
         k++;
         @(negedge clk);
         all_seen = 1'b1;
         for (int s = 0; s < NI; s++) begin
            if (first[s] == 0 && resp[s]) begin
               first[s] = k;
               rd[s] = 1'b0;
               check($sformatf("post_rst_err%0d", s), err[s], 1'b0);
               model_access(s, 1'b1, 1'b0, 16'h0040, 2'b11, 16'h0, e_err, e_known, e_rd);
            end
            if (first[s] == 0) all_seen = 1'b0;
         end
      end
      for (int s = 0; s < NI; s++) begin
         check($sformatf("post_rst_lat%0d", s), first[s], lat_of(s));
         rd[s] = 1'b0;
      end

      // Directed: full write, byte writes, illegal requests
      for (int s = 0; s < NI; s++) begin
         run_access(s, 1'b0, 1'b1, 16'h0040, 2'b11, 16'hBEEF, $sformatf("wr_beef%0d", s));
         run_access(s, 1'b1, 1'b0, 16'h0040, 2'b11, 16'h0000, $sformatf("rd_beef%0d", s));
         run_access(s, 1'b0, 1'b1, 16'h0040, 2'b01, 16'h1234, $sformatf("wr_lo%0d", s));
         run_access(s, 1'b1, 1'b0, 16'h0041, 2'b00, 16'h0000, $sformatf("rd_be34_%0d", s));
         run_access(s, 1'b0, 1'b1, 16'h0040, 2'b10, 16'hAA00, $sformatf("wr_hi%0d", s));
         run_access(s, 1'b1, 1'b0, 16'h0040, 2'b11, 16'h0000, $sformatf("rd_aa34_%0d", s));
         run_access(s, 1'b0, 1'b1, 16'h0040, 2'b00, 16'h5A5A, $sformatf("wr_nomask%0d", s));
         run_access(s, 1'b1, 1'b1, 16'h0040, 2'b11, 16'h0F0F, $sformatf("rej%0d", s));
         run_access(s, 1'b1, 1'b0, 16'h0040, 2'b11, 16'h0000, $sformatf("rd_after_rej%0d", s));
         run_access(s, 1'b1, 1'b0, 16'h0200, 2'b11, 16'h0000, $sformatf("rd_oor%0d", s));
         run_access(s, 1'b0, 1'b1, 16'h0200, 2'b11, 16'h7777, $sformatf("wr_oor%0d", s));
      end

      // Reset during BUSY aborts the write
      for (int s = 1; s < NI; s++) begin
         @(negedge clk);
         wr[s] = 1'b1; addr[s] = 16'h0040; be[s] = 2'b11; wdata[s] = 16'h5555;
         @(posedge clk);
         @(negedge clk);
         rst_n = 1'b0;
         wr[s] = 1'b0;
         @(posedge clk);
         @(negedge clk);
         check($sformatf("abort_resp_in_rst%0d", s), resp[s], 1'b0);
         rst_n = 1'b1;
         for (int i = 0; i < NI; i++) begin
            last_rd[i] = 16'h0000;
            last_known[i] = 1'b1;
         end
         for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("abort_no_resp%0d_%0d", s, c), resp[s], 1'b0);
         end
         run_access(s, 1'b1, 1'b0, 16'h0040, 2'b11, 16'h0000, $sformatf("abort_reread%0d", s));
      end

      // Read held across resp: second acceptance only after RESP->IDLE
      for (int s = 0; s < NI; s++) begin
         @(negedge clk);
         rd[s] = 1'b1; wr[s] = 1'b0; addr[s] = 16'h0040; be[s] = 2'b11;
         k = 0; k1 = 0; k2 = 0;
         while (k2 == 0 && k < 60) begin
            @(posedge clk);
            k++;
            @(negedge clk);
            if (resp[s]) begin
               model_access(s, 1'b1, 1'b0, 16'h0040, 2'b11, 16'h0, e_err, e_known, e_rd);
               check($sformatf("b2b_rdata%0d", s), rdata[s], e_rd);
               if (k1 == 0) k1 = k;
               else k2 = k;
            end
         end
         rd[s] = 1'b0;
         check($sformatf("b2b_first%0d", s), k1, lat_of(s));
         check($sformatf("b2b_gap%0d", s), k2 - k1, lat_of(s) + 1);
      end

      // Randomized traffic: prefill a small window, then mixed accesses
      for (int s = 0; s < NI; s++) begin
         for (int i = 16; i < 24; i++)
            run_access(s, 1'b0, 1'b1, 16'(i * 2), 2'b11, 16'($urandom), $sformatf("fill%0d_%0d", s, i));
         for (int n = 0; n < 30; n++) begin
            int op;
            bit r, w;
            logic [15:0] a;
            op = $urandom_range(0, 9);
            r  = (op == 0) || (op >= 1 && op <= 4);
            w  = (op == 0) || (op >= 5);
            if ($urandom_range(0, 7) == 0)
               a = 16'($urandom_range(256, 32767) * 2 + $urandom_range(0, 1));
            else
               a = 16'($urandom_range(16, 23) * 2 + $urandom_range(0, 1));
            run_access(s, r, w, a, 2'($urandom_range(0, 3)), 16'($urandom),
                       $sformatf("rnd%0d_%0d", s, n));
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
